// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the IF/ID elastic queue.
package fetch_decode_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          FDQ_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] Address;
    logic [31:0] PC4;
  } Fetch_Bundle;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID queue.
interface fetch_decode_queue_if
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);

  Fetch_Bundle      FB;
  logic             fb_valid;
  logic             fb_ready;
  logic             flush;
  logic [31:0]      dq_instr;
  logic [31:0]      dq_address;
  logic [31:0]      dq_pc4;
  logic             dq_valid;
  logic             dq_ready;
  logic [PTR_W:0]   dq_count;

  modport master (
    output FB, fb_valid, flush, dq_ready,
    input  fb_ready, dq_instr, dq_address,
    input  dq_pc4, dq_valid, dq_count
  );

  modport slave (
    input  FB, fb_valid, flush, dq_ready,
    output fb_ready, dq_instr, dq_address,
    output dq_pc4, dq_valid, dq_count
  );

endinterface

// File: rtl/fetch_decode_queue_ptr.sv
// Wrapping queue pointer with synchronous clear and increment.
module fdq_ptr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// IF/ID elastic FIFO with single-cycle flush.
// FDQ_BYPASS_EN adds a zero-latency FB->dq path when empty.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEPTH
) (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  Fetch_Bundle      mem [DEPTH];
  Fetch_Bundle      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             occ;
  logic             byp;
  logic             wr_en;
  logic             rd_en;

  assign occ = (count != '0);

`ifdef FDQ_BYPASS_EN
  assign byp = reset & ~occ & bus.fb_valid & ~bus.flush;
`else
  assign byp = 1'b0;
`endif

  assign bus.fb_ready = (count != FULL);
  assign bus.dq_valid = occ | byp;
  assign bus.dq_count = count;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en = bus.fb_valid & bus.fb_ready & ~bus.flush
               & ~(byp & bus.dq_ready);
  assign rd_en = occ & bus.dq_ready & ~bus.flush;

  fdq_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_en),
    .clr   (bus.flush),
    .ptr   (wr_ptr)
  );

  fdq_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_en),
    .clr   (bus.flush),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= bus.FB;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Empty queue shows a NOP so decode never acts on stale storage.
  always_comb begin
    bus.dq_instr   = NOP_INSTR;
    bus.dq_address = '0;
    bus.dq_pc4     = '0;
    unique case (1'b1)
      byp: begin
        bus.dq_instr   = bus.FB.instr;
        bus.dq_address = bus.FB.Address;
        bus.dq_pc4     = bus.FB.PC4;
      end
      occ: begin
        bus.dq_instr   = head.instr;
        bus.dq_address = head.Address;
        bus.dq_pc4     = head.PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = FDQ_DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_queue_if #(.DEPTH(DEPTH)) bus();

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;
  bit          mon_en = 0;
  Fetch_Bundle exp_q[$];
  Fetch_Bundle cur;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic redirect();
    logic [31:0] t;
    t = $urandom;
    cur.Address = t & 32'hFFFF_FFFC;
    cur.PC4     = cur.Address + 32'd4;
  endtask

  // One cycle of fetch/decode activity plus the reference model update.
  task automatic step(bit v, bit fl, bit rdy);
    bit ready_e, byp, push, pop;
    @(negedge clk);
    bus.fb_valid = v;
    bus.flush    = fl;
    bus.dq_ready = rdy;
    bus.FB       = cur;
    #1;
    ready_e = (mcount != DEPTH);
`ifdef FDQ_BYPASS_EN
    byp = (mcount == 0) && v && !fl;
`else
    byp = 1'b0;
`endif
    chk("fb_ready", 32'(bus.fb_ready), 32'(ready_e));
    chk("dq_valid", 32'(bus.dq_valid), 32'((mcount != 0) || byp));
    chk("dq_count", 32'(bus.dq_count), mcount);
    push = v && ready_e && !fl;
    pop  = ((mcount != 0) || byp) && rdy && !fl;
    if (push) begin
      exp_q.push_back(cur);
      cur.Address = cur.Address + 32'd4;
      cur.PC4     = cur.PC4 + 32'd4;
      cur.instr   = $urandom;
    end
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else if (byp) begin
      if (!rdy) mcount = mcount + 1;
    end else begin
      if (push) mcount = mcount + 1;
      if (pop)  mcount = mcount - 1;
    end
  endtask

  initial begin : monitor
    Fetch_Bundle e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (bus.dq_valid && bus.dq_ready && !bus.flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got %h expected none",
                     bus.dq_address);
          end else begin
            e = exp_q.pop_front();
            chk("pop_instr", bus.dq_instr, e.instr);
            chk("pop_addr", bus.dq_address, e.Address);
            chk("pop_pc4", bus.dq_pc4, e.PC4);
          end
        end else if (!bus.dq_valid) begin
          chk("idle_instr", bus.dq_instr, NOP_INSTR);
          chk("idle_addr", bus.dq_address, 32'd0);
        end
      end
    end
  end

  initial begin
    bit v, fl, rdy;
    bus.fb_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.dq_ready = 1'b0;
    bus.FB       = '0;
    cur = '{instr: 32'h00500093, Address: 32'h0, PC4: 32'h4};
    #1;
    chk("rst_valid", 32'(bus.dq_valid), 32'd0);
    chk("rst_ready", 32'(bus.fb_ready), 32'd1);
    chk("rst_count", 32'(bus.dq_count), 32'd0);
    chk("rst_instr", bus.dq_instr, NOP_INSTR);
    chk("rst_addr", bus.dq_address, 32'd0);
    chk("rst_pc4", bus.dq_pc4, 32'd0);
    #12 reset = 1'b1;
    mon_en = 1;

    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 1);

    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    redirect();
    step(0, 0, 0);

    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      step(v, fl, rdy);
      if (fl) redirect();
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    @(negedge clk);
    mon_en = 0;
    bus.fb_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("async_valid", 32'(bus.dq_valid), 32'd0);
    chk("async_count", 32'(bus.dq_count), 32'd0);
    chk("async_instr", bus.dq_instr, NOP_INSTR);
    exp_q.delete();
    mcount = 0;
    reset = 1'b1;
    mon_en = 1;
    step(0, 0, 0);

    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
